// File: rtl/decode_ibuffer_if.sv
// rtl/decode_ibuffer_if.sv - fetch-side and decode-side handshake bundle for decode_ibuffer
interface decode_ibuffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_insn;
   logic [31:0]   in_pc;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_insn;
   logic [31:0]   out_pc;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_insn, in_pc, out_ready,
      input  in_ready, out_valid, out_insn, out_pc, count
   );

   modport slave (
      input  in_valid, in_insn, in_pc, out_ready,
      output in_ready, out_valid, out_insn, out_pc, count
   );
endinterface

// File: rtl/decode_ibuffer.sv
// rtl/decode_ibuffer.sv - in-order instruction queue between fetch and decode with flush
// DECODE_IBUFFER_BYPASS_EN: empty-buffer zero-latency bypass from fetch to the head.
module decode_ibuffer #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic flush,
   decode_ibuffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [31:0]   insn_mem_q [DEPTH];
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count;
   logic          in_ready;
   logic          stored_valid;
   logic          push;
   logic          pop;
   logic          out_valid;
   logic [31:0]   out_insn;
   logic [31:0]   out_pc;

   // Pointer MSB distinguishes full from empty, so the difference spans 0..DEPTH.
   assign count        = wr_ptr_q - rd_ptr_q;
   assign in_ready     = (count < PW'(DEPTH));
   assign stored_valid = (count != '0);
   assign pop          = stored_valid & bus.out_ready & ~flush;

   always_comb begin
      out_valid = stored_valid;
      out_insn  = '0;
      out_pc    = '0;
      if (stored_valid) begin
         out_insn = insn_mem_q[rd_ptr_q[AW-1:0]];
         out_pc   = pc_mem_q[rd_ptr_q[AW-1:0]];
      end
`ifdef DECODE_IBUFFER_BYPASS_EN
      push = bus.in_valid & in_ready & ~flush;
      if (!stored_valid && bus.in_valid && !flush) begin
         out_valid = 1'b1;
         out_insn  = bus.in_insn;
         out_pc    = bus.in_pc;
         // A bypassed word consumed this cycle never touches storage.
         push      = ~bus.out_ready;
      end
`else
      push = bus.in_valid & in_ready & ~flush;
`endif
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         insn_mem_q[wr_ptr_q[AW-1:0]] <= bus.in_insn;
         pc_mem_q[wr_ptr_q[AW-1:0]]   <= bus.in_pc;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_insn  = out_insn;
   assign bus.out_pc    = out_pc;
   assign bus.count     = count;
endmodule

// File: doc/decode_ibuffer.md
# decode_ibuffer

Instruction queue between fetch and `decode_idecode`. Accepts fetched instruction words with their PCs over a valid/ready handshake, buffers up to `DEPTH` entries in program order, and presents the head entry as `insn`/`valid` to the decoder. Decouples fetch stalls from decode back-pressure and discards all buffered instructions on a pipeline flush such as a branch redirect.

## Interface
- `DEPTH`, default 4: number of entries; a power of two, at least 2.
- `clk  in  1`: clock; all state updates on the rising edge.
- `resetn  in  1`: synchronous reset, active-high (1 = reset), sampled on `clk`.
- `flush  in  1`: synchronous discard of all entries and any same-cycle push.
- `in_valid  in  1`: fetch offers an entry.
- `in_ready  out  1`: buffer can accept; equals `count < DEPTH`.
- `in_insn  in  32`: fetched instruction word.
- `in_pc  in  32`: PC of `in_insn`.
- `out_valid  out  1`: head entry valid; drives decoder `valid`.
- `out_ready  in  1`: decode consumes the head this cycle.
- `out_insn  out  32`: head instruction; drives decoder `insn`.
- `out_pc  out  32`: head PC.
- `count  out  $clog2(DEPTH)+1`: current occupancy, 0..DEPTH.

## Operation
- Storage: circular array of `DEPTH` entries of {insn, pc}. Read and write pointers are `$clog2(DEPTH)+1` bits. The low bits index the array; the MSB marks wrap.
  - Empty: pointers equal.
  - Full: low bits equal and MSBs differ.
- Push = `in_valid & in_ready & ~flush`. It writes at the write pointer, then increments it.
- Pop = `out_valid & out_ready & ~flush`. It increments the read pointer.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged. Allowed at any occupancy below `DEPTH`.
  - at `DEPTH`: `in_ready` is 0, so a push is impossible.
- `in_ready` depends only on registered state, never on `out_ready`. No combinational path from output to input.
- `out_valid = (count != 0)`.
- `out_insn`/`out_pc` show the entry at the read pointer. They are forced to 0 whenever `out_valid` is 0.
- Flush:
  - next cycle both pointers = 0 and `count` = 0.
  - a push offered in the flush cycle is dropped.
  - `out_valid` is 0 from the following cycle.
- Reset: same effect as flush and takes priority over it. Array contents are not cleared.
- Order is strictly FIFO. Entries are never reordered or duplicated.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_insn`=0, `out_pc`=0, `count`=0.
- Latency, base build: entry pushed in cycle N reaches the head no earlier than cycle N+1.
- Pointers wrap silently from `DEPTH`−1 to 0. The MSB toggles on wrap.
- Flush during a full-buffer stall: `in_ready` is 1 in the next cycle.
- Reset mid-stream: all entries are lost. The first post-reset push appears at the head one cycle later.

## Configuration
- `DECODE_IBUFFER_BYPASS_EN` defined: when `count`==0 and `in_valid` is 1 without `flush`:
  - `out_valid`=1, `out_insn`=`in_insn` and `out_pc`=`in_pc` combinationally in the same cycle.
  - if `out_ready` is also 1, the entry is consumed without being written; pointers and `count` unchanged.
  - if `out_ready` is 0, the entry is written as a normal push.
  - Zero-cycle latency through an empty buffer.
- Undefined: no bypass. Minimum latency is 1 cycle and the output is driven only from storage.

## Test plan
- Reset, then push 0x24010001 (pc 0x1000), 0x24020002 (pc 0x1004), `out_ready`=1 -> head shows them in order one cycle after each push; `count` peaks at 1.
- Hold `out_ready`=0 and push 4 entries with DEPTH=4 -> `count`=4, `in_ready`=0, and a fifth `in_valid` is ignored. Release `out_ready` -> 4 entries drain in order, then `out_valid`=0 with `out_insn`=0.
- Stream 10 entries with simultaneous push/pop each cycle at `count`=2 -> `count` stays 2, pointers wrap, and the output PC sequence is contiguous with no gaps.
- Assert `flush` with 3 entries buffered and `in_valid`=1 -> next cycle `count`=0, `out_valid`=0, and the flushed-cycle entry never appears.
- Assert `resetn` mid-stream with `count`=3 -> next cycle all outputs are at reset values; a new push appears at the head one cycle later.
- With `DECODE_IBUFFER_BYPASS_EN`, empty buffer, `in_valid`=1 with 0x0000000C, `out_ready`=1 -> `out_valid`=1 and `out_insn`=0x0000000C in the same cycle, with `count` remaining 0.
